// File: rtl/pipe_stage_skid.sv
// Multi-lane bundle pipeline stage with valid/ready handshake, optional two-entry skid,
// flush/pause from ctrl and a retired-lane counter.
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   ONE   | main entry holds a bundle
//   FULL  | main and skid both hold bundles, upstream stalled (SKID=1 only)
module pipe_stage_skid #(
    parameter int ISSUE_WIDTH = 2,
    parameter int DATA_W      = 64,
    parameter int SKID        = 1,
    parameter int CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          pause,
    input  logic                          in_valid,
    input  logic [ISSUE_WIDTH-1:0]        in_lane_valid,
    input  logic [ISSUE_WIDTH*DATA_W-1:0] in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [ISSUE_WIDTH-1:0]        out_lane_valid,
    output logic [ISSUE_WIDTH*DATA_W-1:0] out_data,
    input  logic                          out_ready,
    output logic [1:0]                    occupancy,
    output logic [CNT_W-1:0]              commit_count
);
    localparam int PW = ISSUE_WIDTH * DATA_W;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t                 state;
    logic                   ready_q;
    logic [ISSUE_WIDTH-1:0] skid_lane_valid;
    logic [PW-1:0]          skid_data;
    logic                   in_fire;
    logic                   out_fire;

    function automatic logic [CNT_W-1:0] popcount(input logic [ISSUE_WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // With the skid, in_ready comes straight from a flop so the upstream ready path is cut.
    always_comb begin
        out_valid = (state != EMPTY) && !pause && !flush;
        in_ready  = (SKID != 0) ? ready_q : ((state == EMPTY) || (out_ready && !pause));
        in_fire   = in_valid && in_ready && !flush;
        out_fire  = out_valid && out_ready;
    end

    assign occupancy = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= EMPTY;
            ready_q         <= 1'b1;
            out_lane_valid  <= '0;
            out_data        <= '0;
            skid_lane_valid <= '0;
            skid_data       <= '0;
            commit_count    <= '0;
        end else if (flush) begin
            state           <= EMPTY;
            ready_q         <= 1'b1;
            out_lane_valid  <= '0;
            out_data        <= '0;
            skid_lane_valid <= '0;
            skid_data       <= '0;
        end else begin
            if (out_fire) commit_count <= commit_count + popcount(out_lane_valid);
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_lane_valid <= in_lane_valid;
                        out_data       <= in_data;
                        state          <= ONE;
                    end
                end
                ONE: begin
                    // Without a skid, in_fire in ONE implies out_fire, so main is simply replaced.
                    if (in_fire && (out_fire || SKID == 0)) begin
                        out_lane_valid <= in_lane_valid;
                        out_data       <= in_data;
                    end else if (in_fire) begin
                        skid_lane_valid <= in_lane_valid;
                        skid_data       <= in_data;
                        state           <= FULL;
                        ready_q         <= 1'b0;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_lane_valid  <= skid_lane_valid;
                        out_data        <= skid_data;
                        skid_lane_valid <= '0;
                        skid_data       <= '0;
                        state           <= ONE;
                        ready_q         <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: SKID=1/CNT_W=4 instance for the main plan, plus a small SKID=0 instance.
module tb_pipe_stage_skid;
    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    logic        flush, pause, in_valid, out_ready;
    logic [1:0]  in_lane_valid;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [1:0]  out_lane_valid, occupancy;
    logic [31:0] out_data;
    logic [3:0]  commit_count;

    logic        z_flush, z_pause, z_in_valid, z_out_ready;
    logic [1:0]  z_in_lane_valid;
    logic [31:0] z_in_data;
    logic        z_in_ready, z_out_valid;
    logic [1:0]  z_out_lane_valid, z_occupancy;
    logic [31:0] z_out_data;
    logic [7:0]  z_commit_count;

    always #5 clk = ~clk;

    pipe_stage_skid #(.ISSUE_WIDTH(2), .DATA_W(16), .SKID(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pause(pause),
        .in_valid(in_valid), .in_lane_valid(in_lane_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_lane_valid(out_lane_valid),
        .out_data(out_data), .out_ready(out_ready), .occupancy(occupancy),
        .commit_count(commit_count)
    );

    pipe_stage_skid #(.ISSUE_WIDTH(2), .DATA_W(16), .SKID(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .flush(z_flush), .pause(z_pause),
        .in_valid(z_in_valid), .in_lane_valid(z_in_lane_valid), .in_data(z_in_data),
        .in_ready(z_in_ready), .out_valid(z_out_valid), .out_lane_valid(z_out_lane_valid),
        .out_data(z_out_data), .out_ready(z_out_ready), .occupancy(z_occupancy),
        .commit_count(z_commit_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] lv, input logic [31:0] d);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_data       = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 0; pause = 0; in_valid = 0; in_lane_valid = 0; in_data = 0; out_ready = 0;
        z_flush = 0; z_pause = 0; z_in_valid = 0; z_in_lane_valid = 0; z_in_data = 0; z_out_ready = 0;
        #3;
        chk("rst_occ", occupancy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", commit_count, 0);
        #4 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Stream A..E, one beat per cycle, each visible one cycle after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(2'b11, 32'hA000_0A00 + 32'(i));
            tick();
            chk("stream_data", out_data, 32'hA000_0A00 + 32'(i));
            chk("stream_valid", out_valid, 1);
            chk("stream_occ", occupancy, 1);
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count", commit_count, 10);
        chk("stream_empty", occupancy, 0);

        // Skid absorbs B while downstream stalls; drains A then B.
        out_ready = 1'b0;
        offer(2'b11, 32'h0000_00AA);
        tick();
        offer(2'b11, 32'h0000_00BB);
        tick();
        chk("skid_occ", occupancy, 2);
        chk("skid_in_ready", in_ready, 0);
        chk("skid_head", out_data, 32'h0000_00AA);
        offer(2'b11, 32'h0000_00CC);
        tick();
        chk("skid_hold_occ", occupancy, 2);
        chk("skid_hold_head", out_data, 32'h0000_00AA);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("skid_second", out_data, 32'h0000_00BB);
        chk("skid_ready_back", in_ready, 1);
        chk("skid_occ1", occupancy, 1);
        chk("skid_count1", commit_count, 12);
        tick();
        chk("skid_count2", commit_count, 14);
        chk("skid_drained", occupancy, 0);

        // Pause holds the bundle and blocks transfer.
        offer(2'b11, 32'h0000_0B0B);
        tick();
        in_valid = 1'b0;
        pause = 1'b1;
        #1;
        chk("pause_valid_now", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_valid", out_valid, 0);
            chk("pause_data", out_data, 32'h0000_0B0B);
            chk("pause_count", commit_count, 14);
            chk("pause_occ", occupancy, 1);
        end
        pause = 1'b0;
        tick();
        chk("pause_release_count", commit_count, 0);
        chk("pause_release_occ", occupancy, 0);
        tick();
        chk("pause_once", commit_count, 0);

        // Flush while FULL with an incoming bundle.
        out_ready = 1'b0;
        offer(2'b11, 32'h0000_0F01);
        tick();
        offer(2'b11, 32'h0000_0F02);
        tick();
        offer(2'b11, 32'h0000_0F03);
        flush = 1'b1;
        #1;
        chk("flush_valid_now", out_valid, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_lv", out_lane_valid, 0);
        chk("flush_data", out_data, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_count", commit_count, 0);

        // Flush in ONE with out_ready high: no transfer, no capture.
        offer(2'b11, 32'h0000_0F04);
        tick();
        out_ready = 1'b1;
        offer(2'b11, 32'h0000_0F05);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush1_occ", occupancy, 0);
        chk("flush1_count", commit_count, 0);

        // Partial lanes and an all-invalid bubble.
        offer(2'b01, 32'h0000_1001);
        tick();
        chk("lane01", out_lane_valid, 2'b01);
        offer(2'b00, 32'h0000_1002);
        tick();
        chk("lane00", out_lane_valid, 2'b00);
        chk("lane00_valid", out_valid, 1);
        chk("lane00_data", out_data, 32'h0000_1002);
        offer(2'b10, 32'h0000_1003);
        tick();
        chk("lane10", out_lane_valid, 2'b10);
        in_valid = 1'b0;
        tick();
        chk("lane_count", commit_count, 2);

        // Asynchronous reset mid-stream, then counter wrap.
        offer(2'b11, 32'h0000_2001);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_occ", occupancy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_count", commit_count, 0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            offer(2'b11, 32'h0000_3000 + 32'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_count", commit_count, 2);

        // SKID=0: full throughput, combinational in_ready.
        z_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            z_in_valid = 1'b1; z_in_lane_valid = 2'b11; z_in_data = 32'h0000_5000 + 32'(i);
            #1;
            chk("z_in_ready", z_in_ready, 1);
            tick();
            chk("z_data", z_out_data, 32'h0000_5000 + 32'(i));
            chk("z_occ", z_occupancy, 1);
        end
        z_in_valid = 1'b0;
        z_out_ready = 1'b0;
        #1;
        chk("z_stall_ready", z_in_ready, 0);
        z_out_ready = 1'b1;
        z_pause = 1'b1;
        #1;
        chk("z_pause_ready", z_in_ready, 0);
        chk("z_pause_valid", z_out_valid, 0);
        z_pause = 1'b0;
        tick();
        chk("z_count", z_commit_count, 6);
        chk("z_empty", z_occupancy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
